// File: rtl/top_level_module_if.sv
// Write/read bus of the FIFO: request and data signals grouped by direction.
// The master drives the requests and W_Data; the FIFO (slave) returns data and flags.
interface top_level_module_if #(
  parameter int DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0] W_Data;
  logic                 W_En;
  logic                 R_En;
  logic [DATAWIDTH-1:0] R_Data;
  logic                 Full;
  logic                 Empty;

  modport master (
    output W_Data, W_En, R_En,
    input  R_Data, Full, Empty
  );

  modport slave (
    input  W_Data, W_En, R_En,
    output R_Data, Full, Empty
  );
endinterface

// File: rtl/top_level_module.sv
// Synchronous FIFO of DATADEPTH x DATAWIDTH entries with a registered read port.
// The depth may be any value >= 2; the pointers wrap explicitly rather than by overflow.
module top_level_module #(
  parameter int DATADEPTH = 45,
  parameter int DATAWIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  top_level_module_if.slave   bus
);
  localparam int CW = $clog2(DATADEPTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(DATADEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(DATADEPTH);

  logic [DATAWIDTH-1:0] mem [DATADEPTH];
  logic [CW-1:0]        wr_ptr;
  logic [CW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [DATAWIDTH-1:0] r_data;

  logic full;
  logic empty;
  logic do_write;
  logic do_read;

  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  // Acceptance uses the flags as they stand before the edge, so a read on
  // an empty FIFO never sees the word written in the same cycle.
  assign do_write = bus.W_En && !full;
  assign do_read  = bus.R_En && !empty;

  assign bus.Full   = full;
  assign bus.Empty  = empty;
  assign bus.R_Data = r_data;

  // NOTE: storage has no reset so it maps onto plain RAM; stale contents are
  // unreachable because the pointers and count are cleared instead.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= bus.W_Data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      r_data <= '0;
    end else begin
      if (do_write) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_read) begin
        r_data <= mem[rd_ptr];
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_top_level_module.sv
// Directed bench for the FIFO: fill, drain, wrap, concurrent traffic, boundary
// cases and asynchronous reset, checked against a reference queue.
module tb_top_level_module;
  localparam int D = 45;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [W-1:0] model_q [$];
  logic [W-1:0] exp_rdata;

  top_level_module_if #(.DATAWIDTH(W)) bus ();

  top_level_module #(.DATADEPTH(D), .DATAWIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] observed,
                       input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock with the given requests; the reference queue follows the same
  // acceptance rule, then outputs and flags are compared 1 ns after the edge.
  task automatic cycle(input logic we, input logic re, input logic [W-1:0] wd,
                       input string tag);
    bit rd_ok, wr_ok;
    bus.W_En   = we;
    bus.R_En   = re;
    bus.W_Data = wd;
    @(posedge clk);
    rd_ok = re && (model_q.size() > 0);
    wr_ok = we && (model_q.size() < D);
    if (rd_ok) exp_rdata = model_q.pop_front();
    if (wr_ok) model_q.push_back(wd);
    #1;
    check({tag, ".rdata"}, bus.R_Data, exp_rdata);
    check({tag, ".empty"}, bus.Empty, model_q.size() == 0);
    check({tag, ".full"},  bus.Full,  model_q.size() == D);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_rdata = '0;
    rst = 1'b0;
    bus.W_En = 1'b1;
    bus.R_En = 1'b1;
    bus.W_Data = 32'd77;

    // Reset held with both enables high: nothing may move.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset.rdata", bus.R_Data, 32'd0);
      check("reset.empty", bus.Empty, 1'b1);
      check("reset.full",  bus.Full,  1'b0);
    end
    bus.W_En = 1'b0;
    bus.R_En = 1'b0;
    rst = 1'b1;

    // Fill 1..45, then an ignored write of 99.
    for (int i = 1; i <= D; i++) begin
      cycle(1'b1, 1'b0, W'(i), "fill");
      if (i == 1) check("fill.first_not_empty", bus.Empty, 1'b0);
    end
    check("fill.full_at_45", bus.Full, 1'b1);
    cycle(1'b1, 1'b0, 32'd99, "fill_over");
    check("fill_over.full_stays", bus.Full, 1'b1);

    // Drain returns 1..45; an extra read holds R_Data at 45.
    for (int i = 1; i <= D; i++) begin
      cycle(1'b0, 1'b1, 32'd0, "drain");
      check("drain.order", bus.R_Data, W'(i));
    end
    check("drain.empty_after", bus.Empty, 1'b1);
    cycle(1'b0, 1'b1, 32'd0, "drain_extra");
    check("drain_extra.hold45", bus.R_Data, 32'd45);

    // Wrap: shift the pointers by 30, then push 40 words across the wrap.
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, W'(200 + i), "wrap_w30");
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 32'd0, "wrap_r30");
    for (int i = 101; i <= 140; i++) cycle(1'b1, 1'b0, W'(i), "wrap_w40");
    for (int i = 101; i <= 140; i++) begin
      cycle(1'b0, 1'b1, 32'd0, "wrap_r40");
      check("wrap.order", bus.R_Data, W'(i));
    end

    // Concurrent traffic at a steady occupancy of 10.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, W'(1000 + i), "conc_pre");
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b1, W'(2000 + i), "conc");
      check("conc.order", bus.R_Data, (i < 10) ? W'(1000 + i) : W'(2000 + i - 10));
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 32'd0, "conc_drain");
      check("conc_drain.order", bus.R_Data, W'(2040 + i));
    end
    check("conc_drain.empty", bus.Empty, 1'b1);

    // Empty with both enables: only the write happens.
    cycle(1'b1, 1'b1, 32'd555, "bnd_empty");
    check("bnd_empty.rdata_hold", bus.R_Data, 32'd2049);
    check("bnd_empty.count1", bus.Empty, 1'b0);
    cycle(1'b0, 1'b1, 32'd0, "bnd_empty_rd");
    check("bnd_empty_rd.word", bus.R_Data, 32'd555);
    check("bnd_empty_rd.empty", bus.Empty, 1'b1);

    // Full with both enables: only the read happens, 4444 is dropped.
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, W'(3000 + i), "bnd_fill");
    cycle(1'b1, 1'b1, 32'd4444, "bnd_full");
    check("bnd_full.read", bus.R_Data, 32'd3000);
    check("bnd_full.count44", bus.Full, 1'b0);
    cycle(1'b1, 1'b0, 32'd5555, "bnd_refill");
    check("bnd_refill.full", bus.Full, 1'b1);
    for (int i = 1; i < D; i++) begin
      cycle(1'b0, 1'b1, 32'd0, "bnd_drain");
      check("bnd_drain.order", bus.R_Data, W'(3000 + i));
    end
    cycle(1'b0, 1'b1, 32'd0, "bnd_last");
    check("bnd_last.not4444", bus.R_Data, 32'd5555);

    // Asynchronous reset mid-operation, then immediate use after release.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, W'(600 + i), "mid_fill");
    #2 rst = 1'b0;
    #1;
    check("mid_rst.empty", bus.Empty, 1'b1);
    check("mid_rst.rdata", bus.R_Data, 32'd0);
    check("mid_rst.full",  bus.Full,  1'b0);
    model_q.delete();
    exp_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b1, 1'b0, 32'd7, "post_rst_w");
    check("post_rst.accept", bus.Empty, 1'b0);
    cycle(1'b0, 1'b1, 32'd0, "post_rst_r");
    check("post_rst.word", bus.R_Data, 32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end
endmodule

// File: doc/top_level_module.md
TOP_LEVEL_MODULE -- requirements
Module: top_level_module

Interface
REQ-001 Parameter DATADEPTH, default 45, number of storage entries; any integer >= 2, not restricted to a power of two.
REQ-002 Parameter DATAWIDTH, default 32, bits per entry.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 W_Data  input  DATAWIDTH  write data, sampled with W_En.
REQ-006 W_En  input  1  write request.
REQ-007 R_En  input  1  read request.
REQ-008 R_Data  output  DATAWIDTH  read data, registered.
REQ-009 Full  output  1  high when DATADEPTH entries are stored.
REQ-010 Empty  output  1  high when no entries are stored.
REQ-011 The block SHALL use one clock (clk) and an asynchronous active-low reset (rst); there are no other clock or reset inputs.

Function
REQ-012 The block SHALL be a synchronous first-in first-out buffer of DATADEPTH entries of DATAWIDTH bits.
REQ-013 Internal state SHALL be a write pointer, a read pointer and an occupancy count, each sized $clog2(DATADEPTH+1) bits or wider.
REQ-014 A write SHALL be accepted on a rising clk edge when W_En=1 and Full=0, storing W_Data at the write pointer and advancing it.
REQ-015 A read SHALL be accepted on a rising clk edge when R_En=1 and Empty=0, loading the entry at the read pointer into R_Data on that edge (one-cycle latency) and advancing the read pointer.
REQ-016 Pointers SHALL wrap from DATADEPTH-1 to 0.
REQ-017 Full and Empty SHALL be combinational decodes of the count (count==DATADEPTH, count==0); the flags used for acceptance are the values before the edge.
REQ-018 Write while Full=1 SHALL be ignored: no storage change, no pointer or count change.
REQ-019 Read while Empty=1 SHALL be ignored; R_Data SHALL hold its previous value.
REQ-020 Simultaneous accepted read and write SHALL leave the count unchanged and advance both pointers.
REQ-021 When Empty=1 and both enables are high, only the write SHALL occur (count 0->1); the written word SHALL NOT appear on R_Data in that cycle.
REQ-022 When Full=1 and both enables are high, only the read SHALL occur (count DATADEPTH->DATADEPTH-1).
REQ-023 R_Data SHALL hold its last value whenever no read is accepted.
REQ-024 Data SHALL exit in the exact order written, with no loss or duplication across pointer wrap.

Reset
REQ-025 While rst=0, regardless of clk: pointers=0, count=0, R_Data=0, Empty=1, Full=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored entries immediately; memory contents need not be cleared.
REQ-027 After rst rises, the first rising clk edge SHALL already accept operations.

Verification
REQ-028 Reset: rst=0 with W_En=R_En=1 toggling clk -> R_Data=0, Empty=1, Full=0 throughout.
REQ-029 Fill: after reset write 1..45 with R_En=0 -> Empty falls after first edge, Full rises after 45th write; a 46th write of 99 is ignored and Full stays 1.
REQ-030 Drain: from full, R_En=1 for 45 cycles -> R_Data = 1,2,...,45 one cycle after each read edge; Empty=1 after the 45th; a further read leaves R_Data=45.
REQ-031 Wrap: write 30, read 30, then write 40 values 101..140 and read them -> same order returned, count never exceeds 40, Full never asserts.
REQ-032 Concurrent: with 10 entries stored, W_En=R_En=1 for 50 cycles -> count stays 10, Full=0, Empty=0, output order preserved.
REQ-033 Boundaries: empty with both enables high -> count becomes 1, R_Data unchanged; full with both enables high -> count becomes 44, new word not stored.
